// File: rtl/keypad_time_encoder_pkg.sv
// Shared definitions for the microwave keypad time-entry encoder:
// digit/key widths, debounce FSM states and the one-hot key helpers.
package keypad_time_encoder_pkg;

   localparam int BCD_W     = 4;
   localparam int KEY_COUNT = 10;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PRESS_DB = 2'd1,
      HELD     = 2'd2,
      REL_DB   = 2'd3
   } kstate_t;

   function automatic logic key_valid(input logic [KEY_COUNT-1:0] oh);
      return $onehot(oh);
   endfunction

   function automatic logic [BCD_W-1:0] oh2bcd(input logic [KEY_COUNT-1:0] oh);
      logic [BCD_W-1:0] r;
      r = '0;
      for (int i = 0; i < KEY_COUNT; i++)
         if (oh[i]) r = BCD_W'(i);
      return r;
   endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Keypad synchroniser and press/release debounce FSM.
// Emits a one-cycle accept with the BCD code of the debounced key.
module keypad_debounce
   import keypad_time_encoder_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_W           = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [KEY_COUNT-1:0] keypad,
   output logic                 accept,
   output logic [BCD_W-1:0]     code
);

   logic [KEY_COUNT-1:0] sync1, ks;
   logic [1:0]           vld;
   logic                 armed;
   kstate_t              state, state_n;
   logic [CNT_W-1:0]     cnt, cnt_n;
   logic [KEY_COUNT-1:0] cand, cand_n;

   // A key already down across reset stays ignored until all keys release.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         ks    <= '0;
         vld   <= '0;
         armed <= 1'b0;
         state <= IDLE;
         cnt   <= '0;
         cand  <= '0;
      end else begin
         sync1 <= keypad;
         ks    <= sync1;
         vld   <= {vld[0], 1'b1};
         armed <= armed | (vld[1] & ~|ks);
         state <= state_n;
         cnt   <= cnt_n;
         cand  <= cand_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      cand_n  = cand;
      accept  = 1'b0;
      unique case (state)
         IDLE: begin
            if (armed && key_valid(ks)) begin
               state_n = PRESS_DB;
               cand_n  = ks;
               cnt_n   = CNT_W'(1);
            end
         end
         PRESS_DB: begin
            if (ks != cand) begin
               state_n = IDLE;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
               accept  = 1'b1;
               state_n = HELD;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         HELD: begin
            if (ks == '0) begin
               state_n = REL_DB;
               cnt_n   = CNT_W'(1);
            end
         end
         REL_DB: begin
            if (ks != '0)
               state_n = HELD;
            else if (cnt == CNT_W'(DEBOUNCE_CYCLES))
               state_n = IDLE;
            else
               cnt_n = cnt + CNT_W'(1);
         end
         default: state_n = IDLE;
      endcase
   end

   assign code = oh2bcd(cand);

endmodule

// File: rtl/keypad_time_encoder.sv
// Microwave time entry: debounced keys shift into min/sec_tens/sec_ones
// from the right; sec_over flags an un-normalised tens-of-seconds digit.
module keypad_time_encoder
   import keypad_time_encoder_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_W           = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [KEY_COUNT-1:0] keypad,
   input  logic                 load_en,
   input  logic                 clear_entry,
   output logic [BCD_W-1:0]     min,
   output logic [BCD_W-1:0]     sec_tens,
   output logic [BCD_W-1:0]     sec_ones,
   output logic                 key_strobe,
   output logic [BCD_W-1:0]     key_code,
   output logic                 sec_over
);

   logic             accept;
   logic [BCD_W-1:0] code;

   keypad_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_db (
      .clk    (clk),
      .reset  (reset),
      .keypad (keypad),
      .accept (accept),
      .code   (code)
   );

   // sec_over tracks the value sec_tens takes on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         min        <= '0;
         sec_tens   <= '0;
         sec_ones   <= '0;
         key_strobe <= 1'b0;
         key_code   <= '0;
         sec_over   <= 1'b0;
      end else begin
         key_strobe <= accept;
         if (accept) key_code <= code;
         if (clear_entry) begin
            min      <= '0;
            sec_tens <= '0;
            sec_ones <= '0;
            sec_over <= 1'b0;
         end else if (accept && load_en) begin
            min      <= sec_tens;
            sec_tens <= sec_ones;
            sec_ones <= code;
            sec_over <= (sec_ones > BCD_W'(5));
         end
      end
   end

endmodule

// File: tb/tb_keypad_time_encoder.sv
// Self-checking bench for keypad_time_encoder: vector table, corner
// sequences and randomized presses against a time-entry reference model.
module tb_keypad_time_encoder;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] keypad;
   logic       load_en;
   logic       clear_entry;
   logic [3:0] min, sec_tens, sec_ones, key_code;
   logic       key_strobe, sec_over;

   int total = 0;
   int bad   = 0;
   int scnt  = 0;

   keypad_time_encoder #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .keypad      (keypad),
      .load_en     (load_en),
      .clear_entry (clear_entry),
      .min         (min),
      .sec_tens    (sec_tens),
      .sec_ones    (sec_ones),
      .key_strobe  (key_strobe),
      .key_code    (key_code),
      .sec_over    (sec_over)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #2;
      if (key_strobe) scnt++;
   end

   typedef struct {
      int key;
      bit ld;
      bit clr;
      int exp_num;
      bit exp_over;
   } vec_t;

   vec_t tbl[14];

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic int num();
      return int'(min) * 100 + int'(sec_tens) * 10 + int'(sec_ones);
   endfunction

   task automatic press(input int k, input int hold, input int rel);
      keypad = '0;
      keypad[k] = 1'b1;
      cyc(hold);
      keypad = '0;
      cyc(rel);
   endtask

   task automatic pulse_clear();
      clear_entry = 1'b1;
      cyc(1);
      clear_entry = 1'b0;
      cyc(2);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int s0, lat, entry, code, k, ld, was;

      tbl = '{
         '{1, 1, 0,   1, 0}, '{3, 1, 0,  13, 0}, '{0, 1, 0, 130, 0},
         '{1, 1, 1,   1, 0}, '{2, 1, 0,  12, 0}, '{3, 1, 0, 123, 0},
         '{4, 1, 0, 234, 0}, '{0, 1, 1,   0, 0}, '{9, 1, 0,   9, 0},
         '{9, 1, 0,  99, 1}, '{6, 0, 0,  99, 1}, '{7, 1, 0, 997, 1},
         '{2, 1, 0, 972, 1}, '{5, 1, 0, 725, 0}
      };

      reset = 1'b1;
      keypad = '0;
      load_en = 1'b1;
      clear_entry = 1'b0;
      cyc(3);
      chk("reset_digits", num(), 0);
      chk("reset_code", int'(key_code), 0);
      chk("reset_flags", int'({key_strobe, sec_over}), 0);
      reset = 1'b0;

      for (int i = 0; i < 50; i++) begin
         cyc(1);
         chk("idle_outputs",
             int'({min, sec_tens, sec_ones, key_code, key_strobe, sec_over}), 0);
      end
      chk("idle_strobes", scnt, 0);

      for (int i = 0; i < 14; i++) begin
         if (tbl[i].clr) pulse_clear();
         load_en = tbl[i].ld;
         s0 = scnt;
         press(tbl[i].key, 10, 10);
         chk("tbl_strobe", scnt - s0, 1);
         chk("tbl_code", int'(key_code), tbl[i].key);
         chk("tbl_digits", num(), tbl[i].exp_num);
         chk("tbl_over", int'(sec_over), int'(tbl[i].exp_over));
      end
      load_en = 1'b1;

      // bounce on/off then stable key 5
      was = num();
      s0 = scnt;
      keypad = 10'd1 << 5;
      cyc(1);
      keypad = '0;
      cyc(1);
      keypad = 10'd1 << 5;
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         cyc(1);
         if (key_strobe && lat == 0) lat = i;
      end
      keypad = '0;
      cyc(12);
      chk("bounce_latency", lat, D + 3);
      chk("bounce_strobes", scnt - s0, 1);
      chk("bounce_digits", num(), (was * 10 + 5) % 1000);

      // two keys together
      was = num();
      s0 = scnt;
      keypad = (10'd1 << 2) | (10'd1 << 7);
      cyc(20);
      keypad = '0;
      cyc(10);
      chk("dual_strobes", scnt - s0, 0);
      chk("dual_digits", num(), was);

      // clear_entry on the accept cycle of key 8
      s0 = scnt;
      keypad = 10'd1 << 8;
      cyc(D + 2);
      clear_entry = 1'b1;
      cyc(1);
      clear_entry = 1'b0;
      chk("clracc_strobe", int'(key_strobe), 1);
      chk("clracc_digits", num(), 0);
      chk("clracc_code", int'(key_code), 8);
      keypad = '0;
      cyc(12);
      chk("clracc_count", scnt - s0, 1);
      chk("clracc_over", int'(sec_over), 0);

      // preload, then reset in the middle of a press debounce
      press(9, 10, 10);
      s0 = scnt;
      keypad = 10'd1 << 3;
      cyc(4);
      reset = 1'b1;
      #1;
      chk("rstmid_digits", num(), 0);
      chk("rstmid_code", int'(key_code), 0);
      cyc(2);
      reset = 1'b0;
      cyc(30);
      keypad = '0;
      cyc(10);
      chk("rstmid_strobes", scnt - s0, 0);
      chk("rstmid_after", num(), 0);
      s0 = scnt;
      press(3, 10, 10);
      chk("rstmid_repress", scnt - s0, 1);
      chk("rstmid_repdig", num(), 3);

      // randomized clean presses against a time-entry model
      entry = num();
      code = int'(key_code);
      for (int i = 0; i < 40; i++) begin
         k = int'($urandom_range(0, 9));
         ld = ($urandom_range(0, 3) != 0) ? 1 : 0;
         if ($urandom_range(0, 5) == 0) begin
            pulse_clear();
            entry = 0;
         end
         load_en = ld[0];
         s0 = scnt;
         press(k, int'($urandom_range(D + 2, 12)), int'($urandom_range(D + 3, 12)));
         if (ld != 0) entry = (entry * 10 + k) % 1000;
         code = k;
         chk("rnd_strobe", scnt - s0, 1);
         chk("rnd_code", int'(key_code), code);
         chk("rnd_digits", num(), entry);
         chk("rnd_over", int'(sec_over), ((entry / 10) % 10 > 5) ? 1 : 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
